// File: rtl/lcd_pkg.sv
// Shared FSM state type, HD44780 command bytes, delays and hex conversion
// for the character-LCD hex display.
package lcd_pkg;

   typedef enum logic [3:0] {
      StPwrup,
      StInit,
      StLoad,
      StL1Addr,
      StL1Chr,
      StL2Addr,
      StL2Chr,
      StHoldoff,
      StIdle
   } lcd_state_e;

   localparam logic [7:0] LCD_FUNCSET = 8'h28;
   localparam logic [7:0] LCD_DISPON  = 8'h0C;
   localparam logic [7:0] LCD_ENTRY   = 8'h06;
   localparam logic [7:0] LCD_CLEAR   = 8'h01;
   localparam logic [7:0] LCD_LINE1   = 8'h80;
   localparam logic [7:0] LCD_LINE2   = 8'hC0;

   localparam int unsigned PWRUP_US      = 20000;
   localparam logic [15:0] INIT_WAIT1_US = 16'd5000;
   localparam logic [15:0] INIT_WAIT2_US = 16'd200;
   localparam logic [15:0] CMD_US        = 16'd40;
   localparam logic [15:0] CLEAR_US      = 16'd2000;

   function automatic logic [7:0] hex2ascii(input logic [3:0] nibble, input logic upper);
      if (nibble < 4'd10) begin
         return 8'h30 + {4'h0, nibble};
      end
      return (upper ? 8'h41 : 8'h61) + {4'h0, nibble} - 8'd10;
   endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// 4-bit HD44780 write engine: one byte (or a lone high nibble) with
// setup/strobe/hold timing in microsecond units, then a post-wait.
module lcd_byte_tx #(
   parameter int unsigned CLK_MHZ = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        rs,
   input  logic [7:0]  data_byte,
   input  logic        nibble_only,
   input  logic [15:0] post_wait_us,
   output logic        done,
   output logic        lcd_e,
   output logic        lcd_rs,
   output logic [3:0]  lcd_dat
);

   localparam int unsigned Unit   = (CLK_MHZ < 1) ? 1 : CLK_MHZ;
   localparam logic [31:0] CycMax = 32'(Unit - 1);

   typedef enum logic [2:0] {TxIdle, TxSetup, TxPulse, TxHold, TxGap, TxPost} tx_state_e;

   tx_state_e   state_q;
   logic [31:0] cyc_q;
   logic [15:0] us_q;
   logic        low_q;
   logic        nib_only_q;
   logic [3:0]  low_nib_q;
   logic [15:0] post_q;
   logic        phase_end;

   // Each phase lasts (us_q + 1) microseconds counted from cyc_q = 0.
   assign phase_end = (cyc_q == CycMax) && (us_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= TxIdle;
         cyc_q      <= '0;
         us_q       <= '0;
         low_q      <= 1'b0;
         nib_only_q <= 1'b0;
         low_nib_q  <= '0;
         post_q     <= '0;
         done       <= 1'b0;
         lcd_e      <= 1'b0;
         lcd_rs     <= 1'b0;
         lcd_dat    <= '0;
      end else begin
         done <= 1'b0;
         if (state_q != TxIdle) begin
            if (cyc_q == CycMax) begin
               cyc_q <= '0;
               if (us_q != '0) us_q <= us_q - 16'd1;
            end else begin
               cyc_q <= cyc_q + 32'd1;
            end
         end
         unique case (state_q)
            TxIdle: begin
               if (start) begin
                  low_nib_q  <= data_byte[3:0];
                  nib_only_q <= nibble_only;
                  post_q     <= post_wait_us;
                  low_q      <= 1'b0;
                  lcd_rs     <= rs;
                  lcd_dat    <= data_byte[7:4];
                  lcd_e      <= 1'b0;
                  cyc_q      <= '0;
                  us_q       <= '0;
                  state_q    <= TxSetup;
               end
            end
            TxSetup: begin
               if (phase_end) begin
                  lcd_e   <= 1'b1;
                  state_q <= TxPulse;
               end
            end
            TxPulse: begin
               if (phase_end) begin
                  lcd_e   <= 1'b0;
                  state_q <= TxHold;
               end
            end
            TxHold: begin
               if (phase_end) begin
                  if (!low_q && !nib_only_q) begin
                     state_q <= TxGap;
                  end else begin
                     state_q <= TxPost;
                     us_q    <= (post_q == '0) ? '0 : post_q - 16'd1;
                  end
               end
            end
            TxGap: begin
               if (phase_end) begin
                  lcd_dat <= low_nib_q;
                  low_q   <= 1'b1;
                  state_q <= TxSetup;
               end
            end
            TxPost: begin
               if (phase_end) begin
                  done    <= 1'b1;
                  state_q <= TxIdle;
               end
            end
            default: state_q <= TxIdle;
         endcase
      end
   end

endmodule

// File: rtl/lcd_hex_display.sv
// HD44780 debug display: label on line 1, right-aligned hex value on line 2,
// redrawn only when the inputs change, at most once per holdoff period.
module lcd_hex_display
   import lcd_pkg::*;
#(
   parameter int unsigned CLK_MHZ    = 100,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned HEX_UPPER  = 1,
   parameter int unsigned HOLDOFF_US = 100000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [127:0]          label,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  hold,
   output logic                  busy,
   output logic                  lcd_e,
   output logic                  lcd_rs,
   output logic                  lcd_rw,
   output logic [3:0]            lcd_dat
);

   localparam int unsigned Unit        = (CLK_MHZ < 1) ? 1 : CLK_MHZ;
   localparam int unsigned HoldUs      = (HOLDOFF_US < 1) ? 1 : HOLDOFF_US;
   localparam logic [31:0] PwrupCycles = 32'(PWRUP_US * Unit - 1);
   localparam logic [31:0] HoldCycles  = 32'(HoldUs * Unit - 1);
   localparam int          Pad         = 16 - int'(DATA_WIDTH / 4);

   lcd_state_e            state_q;
   logic [31:0]           timer_q;
   logic [3:0]            idx_q;
   logic                  pend_q;
   logic                  tx_start_q;
   logic                  busy_q;
   logic [127:0]          label_snap_q;
   logic [DATA_WIDTH-1:0] data_snap_q;

   logic                  tx_done;
   logic                  tx_rs;
   logic                  tx_nib;
   logic [7:0]            tx_byte;
   logic [15:0]           tx_post;

   // Digit at position pos counts nibbles from the LSB as 15 - pos.
   function automatic logic [7:0] line2_char(input logic [3:0] pos,
                                             input logic [DATA_WIDTH-1:0] val);
      if (int'(pos) < Pad) return 8'h20;
      return hex2ascii(4'(val >> (4 * (15 - int'(pos)))), HEX_UPPER != 0);
   endfunction

   always_comb begin
      tx_rs   = 1'b0;
      tx_nib  = 1'b0;
      tx_byte = 8'h00;
      tx_post = CMD_US;
      unique case (state_q)
         StInit: begin
            tx_nib = (idx_q < 4'd4);
            case (idx_q)
               4'd0: begin
                  tx_byte = 8'h30;
                  tx_post = INIT_WAIT1_US;
               end
               4'd1: begin
                  tx_byte = 8'h30;
                  tx_post = INIT_WAIT2_US;
               end
               4'd2: tx_byte = 8'h30;
               4'd3: tx_byte = 8'h20;
               4'd4: tx_byte = LCD_FUNCSET;
               4'd5: tx_byte = LCD_DISPON;
               4'd6: tx_byte = LCD_ENTRY;
               default: begin
                  tx_byte = LCD_CLEAR;
                  tx_post = CLEAR_US;
               end
            endcase
         end
         StL1Addr: tx_byte = LCD_LINE1;
         StL1Chr: begin
            tx_rs   = 1'b1;
            tx_byte = label_snap_q[8 * (15 - int'(idx_q)) +: 8];
         end
         StL2Addr: tx_byte = LCD_LINE2;
         StL2Chr: begin
            tx_rs   = 1'b1;
            tx_byte = line2_char(idx_q, data_snap_q);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StPwrup;
         timer_q      <= PwrupCycles;
         idx_q        <= '0;
         pend_q       <= 1'b0;
         tx_start_q   <= 1'b0;
         busy_q       <= 1'b1;
         label_snap_q <= '0;
         data_snap_q  <= '0;
      end else begin
         tx_start_q <= 1'b0;
         unique case (state_q)
            StPwrup: begin
               if (timer_q == '0) begin
                  state_q <= StInit;
                  idx_q   <= '0;
               end else begin
                  timer_q <= timer_q - 32'd1;
               end
            end
            StLoad: begin
               label_snap_q <= label;
               data_snap_q  <= data;
               state_q      <= StL1Addr;
            end
            StHoldoff: begin
               if (timer_q == '0) state_q <= StIdle;
               else timer_q <= timer_q - 32'd1;
            end
            StIdle: begin
               if (!hold && (label != label_snap_q || data != data_snap_q)) begin
                  state_q <= StLoad;
                  busy_q  <= 1'b1;
               end
            end
            default: begin
               // Transfer states: launch one item, advance when the engine finishes it.
               if (!pend_q) begin
                  tx_start_q <= 1'b1;
                  pend_q     <= 1'b1;
               end else if (tx_done) begin
                  pend_q <= 1'b0;
                  idx_q  <= idx_q + 4'd1;
                  case (state_q)
                     StInit: begin
                        if (idx_q == 4'd7) begin
                           state_q <= StLoad;
                           idx_q   <= '0;
                        end
                     end
                     StL1Addr: begin
                        state_q <= StL1Chr;
                        idx_q   <= '0;
                     end
                     StL1Chr: if (idx_q == 4'd15) state_q <= StL2Addr;
                     StL2Addr: begin
                        state_q <= StL2Chr;
                        idx_q   <= '0;
                     end
                     StL2Chr: begin
                        if (idx_q == 4'd15) begin
                           state_q <= StHoldoff;
                           timer_q <= HoldCycles;
                           busy_q  <= 1'b0;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

   lcd_byte_tx #(
      .CLK_MHZ(CLK_MHZ)
   ) u_byte_tx (
      .clk         (clk),
      .rst         (rst),
      .start       (tx_start_q),
      .rs          (tx_rs),
      .data_byte   (tx_byte),
      .nibble_only (tx_nib),
      .post_wait_us(tx_post),
      .done        (tx_done),
      .lcd_e       (lcd_e),
      .lcd_rs      (lcd_rs),
      .lcd_dat     (lcd_dat)
   );

   assign lcd_rw = 1'b0;
   assign busy   = busy_q;

endmodule

// File: tb/tb_lcd_hex_display.sv
// Bench for lcd_hex_display: nibble scoreboard on each lcd_e strobe plus
// directed timing, hold and reset steps; a second instance covers 64-bit lowercase.
module tb_lcd_hex_display;

   logic         clk = 1'b0;
   logic         rst;
   logic         rst_b;
   logic         hold;
   logic [127:0] label;
   logic [31:0]  data;
   logic         busy, lcd_e, lcd_rs, lcd_rw;
   logic [3:0]   lcd_dat;
   logic         busy_b, e_b, rs_b, rw_b;
   logic [3:0]   dat_b;

   localparam logic [63:0] DataB = 64'h0123456789ABCDEF;
   localparam string       Lbl   = "* Hello World! *";

   int         checks = 0;
   int         failures = 0;
   int         strobes = 0;
   int         rs1_strobes = 0;
   logic [4:0] exp_q[$];
   logic [4:0] expb_q[$];
   logic       e_prev = 1'b0;
   logic       eb_prev = 1'b0;

   always #5 clk = ~clk;

   lcd_hex_display #(
      .CLK_MHZ(1), .DATA_WIDTH(32), .HEX_UPPER(1), .HOLDOFF_US(500)
   ) dut (
      .clk(clk), .rst(rst), .label(label), .data(data), .hold(hold), .busy(busy),
      .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_dat(lcd_dat)
   );

   lcd_hex_display #(
      .CLK_MHZ(1), .DATA_WIDTH(64), .HEX_UPPER(0), .HOLDOFF_US(500)
   ) dut_b (
      .clk(clk), .rst(rst_b), .label(label), .data(DataB), .hold(1'b0), .busy(busy_b),
      .lcd_e(e_b), .lcd_rs(rs_b), .lcd_rw(rw_b), .lcd_dat(dat_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      e_prev <= lcd_e;
      if (lcd_e && !e_prev) begin
         strobes++;
         if (lcd_rs) rs1_strobes++;
         if (exp_q.size() != 0) begin
            check("nibble_a", 64'({lcd_rs, lcd_dat}), 64'(exp_q.pop_front()));
         end else begin
            checks++;
            failures++;
            $error("FAIL unexpected_strobe_a observed=%0h expected=none", {lcd_rs, lcd_dat});
         end
      end
   end

   always @(negedge clk) begin
      eb_prev <= e_b;
      if (e_b && !eb_prev) begin
         if (expb_q.size() != 0) begin
            check("nibble_b", 64'({rs_b, dat_b}), 64'(expb_q.pop_front()));
         end else begin
            checks++;
            failures++;
            $error("FAIL unexpected_strobe_b observed=%0h expected=none", {rs_b, dat_b});
         end
      end
   end

   task automatic push_nib(input bit to_b, input logic [4:0] v);
      if (to_b) expb_q.push_back(v);
      else exp_q.push_back(v);
   endtask

   task automatic push_byte(input bit to_b, input logic rs, input logic [7:0] b);
      push_nib(to_b, {rs, b[7:4]});
      push_nib(to_b, {rs, b[3:0]});
   endtask

   task automatic push_init(input bit to_b);
      push_nib(to_b, 5'h03);
      push_nib(to_b, 5'h03);
      push_nib(to_b, 5'h03);
      push_nib(to_b, 5'h02);
      push_byte(to_b, 1'b0, 8'h28);
      push_byte(to_b, 1'b0, 8'h0C);
      push_byte(to_b, 1'b0, 8'h06);
      push_byte(to_b, 1'b0, 8'h01);
   endtask

   task automatic push_refresh(input bit to_b, input string l1, input string l2);
      push_byte(to_b, 1'b0, 8'h80);
      for (int i = 0; i < 16; i++) push_byte(to_b, 1'b1, l1[i]);
      push_byte(to_b, 1'b0, 8'hC0);
      for (int i = 0; i < 16; i++) push_byte(to_b, 1'b1, l2[i]);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_busy(input string tag, input bit on_b, input logic lvl, input int budget,
                            output int waited);
      waited = 0;
      while ((on_b ? busy_b : busy) !== lvl && waited < budget) begin
         @(negedge clk);
         waited++;
      end
      check(tag, 64'(on_b ? busy_b : busy), 64'(lvl));
   endtask

   initial begin
      int w;
      int s0;
      int lo;
      rst   = 1'b1;
      rst_b = 1'b1;
      hold  = 1'b0;
      label = "* Hello World! *";
      data  = 32'hDEADBEEF;
      cycles(3);
      check("rst_lcd_e", 64'(lcd_e), 64'd0);
      check("rst_lcd_rs", 64'(lcd_rs), 64'd0);
      check("rst_lcd_rw", 64'(lcd_rw), 64'd0);
      check("rst_lcd_dat", 64'(lcd_dat), 64'd0);
      check("rst_busy", 64'(busy), 64'd1);

      push_init(1'b0);
      push_refresh(1'b0, Lbl, "        DEADBEEF");
      push_init(1'b1);
      push_refresh(1'b1, Lbl, "0123456789abcdef");
      rst   = 1'b0;
      rst_b = 1'b0;
      s0 = strobes;
      cycles(20000);
      check("pwrup_quiet", 64'(strobes - s0), 64'd0);
      check("pwrup_busy", 64'(busy), 64'd1);
      wait_busy("first_refresh_done", 1'b0, 1'b0, 40000, w);
      check("first_queue_drained", 64'(exp_q.size()), 64'd0);
      wait_busy("b_refresh_done", 1'b1, 1'b0, 1000, w);
      check("b_queue_drained", 64'(expb_q.size()), 64'd0);

      // Changes during holdoff and mid-refresh collapse into one later refresh.
      data = 32'h1;
      push_refresh(1'b0, Lbl, "        00000001");
      wait_busy("refresh1_start", 1'b0, 1'b1, 1000, w);
      cycles(200);
      data = 32'h2;
      cycles(200);
      data = 32'h3;
      push_refresh(1'b0, Lbl, "        00000003");
      wait_busy("refresh1_done", 1'b0, 1'b0, 5000, w);
      check("refresh1_left_68", 64'(exp_q.size()), 64'd68);
      wait_busy("refresh3_start", 1'b0, 1'b1, 2000, lo);
      check("holdoff_len_ok", 64'(lo >= 500 && lo <= 510), 64'd1);
      wait_busy("refresh3_done", 1'b0, 1'b0, 5000, w);
      check("refresh3_queue_drained", 64'(exp_q.size()), 64'd0);
      s0 = strobes;
      cycles(2000);
      check("no_extra_refresh", 64'(strobes - s0), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);

      hold = 1'b1;
      data = 32'h5;
      s0 = strobes;
      cycles(2000);
      check("hold_quiet", 64'(strobes - s0), 64'd0);
      check("hold_busy", 64'(busy), 64'd0);
      push_refresh(1'b0, Lbl, "        00000005");
      hold = 1'b0;
      wait_busy("hold_release_start", 1'b0, 1'b1, 2, w);
      wait_busy("refresh5_done", 1'b0, 1'b0, 5000, w);
      check("refresh5_queue_drained", 64'(exp_q.size()), 64'd0);

      // Reset in the middle of line-1 characters restarts everything.
      data = 32'h6;
      push_refresh(1'b0, Lbl, "        00000006");
      wait_busy("refresh6_start", 1'b0, 1'b1, 1000, w);
      s0 = rs1_strobes;
      w = 0;
      while (rs1_strobes == s0 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      check("reached_l1chr", 64'(rs1_strobes > s0), 64'd1);
      cycles(1);
      exp_q.delete();
      rst = 1'b1;
      cycles(1);
      check("midrst_lcd_e", 64'(lcd_e), 64'd0);
      check("midrst_lcd_dat", 64'(lcd_dat), 64'd0);
      check("midrst_busy", 64'(busy), 64'd1);
      push_init(1'b0);
      push_refresh(1'b0, Lbl, "        00000006");
      rst = 1'b0;
      s0 = strobes;
      cycles(20000);
      check("repwrup_quiet", 64'(strobes - s0), 64'd0);
      wait_busy("rerefresh_done", 1'b0, 1'b0, 40000, w);
      check("rerefresh_queue_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lcd_hex_display.md
Name: lcd_hex_display

Overview:
Self-contained HD44780 character-LCD debug display; it is the parametrised successor to the current label/data LCD display.
- Owns the 4-bit write engine and its power-up/init sequence; it does not reset the LCD on every change.
- Shows a 16-character label on line 1 and a DATA_WIDTH-bit value as right-aligned hex on line 2.
- Rewrites only on content change, rate-limited, with a hold input and a busy status.

Parameters:
CLK_MHZ, 100, clock frequency in MHz; 1 us = CLK_MHZ cycles (minimum 1).
DATA_WIDTH, 32, displayed value width; multiple of 4, range 4..64.
HEX_UPPER, 1, 1 = digits 'A'-'F', 0 = 'a'-'f'.
HOLDOFF_US, 100000, minimum time from end of one refresh to start of the next.

Ports:
clk  in  1  system clock; one clock domain.
rst  in  1  reset, synchronous, active-high.
label  in  128  line-1 text; [127:120] is the leftmost character.
data  in  DATA_WIDTH  value shown on line 2.
hold  in  1  1 = freeze display; changes are not accepted.
busy  out  1  1 during power-up, init or refresh.
lcd_e  out  1  LCD enable strobe.
lcd_rs  out  1  0 = command, 1 = character.
lcd_rw  out  1  tied 0 (write-only).
lcd_dat  out  4  LCD data nibble.

Behaviour:
- Reset (sampled on clk edge): lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_dat=0, busy=1.
  - Snapshots cleared; holdoff timer cleared; FSM returns to PWRUP.
  - rst mid-operation aborts immediately and restarts the full sequence.
- Nibble transfer (U = CLK_MHZ cycles):
  - lcd_rs/lcd_dat driven with lcd_e=0 for U cycles.
  - lcd_e=1 for U cycles.
  - lcd_e=0 for U cycles, with rs/dat held.
- Byte transfer: high nibble, then 1 us gap, then low nibble, then post-wait.
  - Post-wait is 40 us for all bytes, 2000 us after clear (0x01).
- FSM states and transitions:
  - PWRUP: wait 20000 us.
  - INIT: single nibbles 0x3 (wait 5000 us), 0x3 (wait 200 us), 0x3 (wait 40 us), 0x2 (wait 40 us).
  - INIT continued: bytes 0x28, 0x0C, 0x06, 0x01, all rs=0.
  - LOAD: capture label/data into snapshots.
  - L1ADDR: byte 0x80.
  - L1CHR: 16 label bytes, rs=1.
  - L2ADDR: byte 0xC0.
  - L2CHR: 16 line-2 bytes, rs=1.
  - HOLDOFF: wait HOLDOFF_US.
  - IDLE.
  - After INIT, go to LOAD unconditionally; this is the first refresh.
  - IDLE -> LOAD when hold=0 and (label != label_snap or data != data_snap).
- busy: 1 from reset through the end of L2CHR; 0 in HOLDOFF and IDLE; 1 again from LOAD.
- Line 2 contents: 16 - DATA_WIDTH/4 spaces (0x20), then hex digits MS nibble first, from the snapshot.
- Input changes during a refresh:
  - Never abort or corrupt the refresh; the snapshot is stable.
  - Picked up by the IDLE compare after holdoff.
  - Several changes within one holdoff produce exactly one refresh with the latest values.
- hold=1 during a refresh does not stop that refresh; it only blocks IDLE -> LOAD.

Decomposition:
- Package lcd_pkg:
  - FSM state enum.
  - Command constants: LCD_FUNCSET=8'h28, LCD_DISPON=8'h0C, LCD_ENTRY=8'h06, LCD_CLEAR=8'h01, LCD_LINE1=8'h80, LCD_LINE2=8'hC0.
  - Delay constants in us.
  - Function hex2ascii(nibble, upper).
- Sub-module lcd_byte_tx:
  - Inputs: start, rs, byte, nibble_only, post_wait_us.
  - Outputs: done pulse, lcd_e/rs/dat.
  - Implements nibble timing and post-wait.
- Top level sequences states, snapshots, compare and holdoff.

Test Plan (CLK_MHZ=1, HOLDOFF_US=500):
- Release rst -> lcd_e=0 for 20000 cycles, busy=1; first lcd_e rise has rs=0, dat=4'h3.
- Init capture -> nibble stream starts 3,3,3,2,2,8,0,C,0,6,0,1 (rs=0), then 8,0, then 32 nibbles rs=1, then C,0, then 32 nibbles rs=1; busy falls after the last nibble.
- label="* Hello World! *", data=32'hDEADBEEF:
  - Line-1 bytes equal the label.
  - Line-2 bytes are "        DEADBEEF" (eight 0x20, then 0x44,0x45,0x41,0x44,0x42,0x45,0x45,0x46).
  - With HEX_UPPER=0, line 2 is "deadbeef".
  - With DATA_WIDTH=64 and data=64'h0123456789ABCDEF, line 2 is all 16 digits with no spaces.
- Change data to 32'h1, then 32'h2, then 32'h3 mid-refresh:
  - Current refresh completes unchanged.
  - After 500 cycles of holdoff, exactly one refresh shows "        00000003".
- Idle, hold=1, change data to 32'h5 -> no lcd_e activity for 2000 cycles; drop hold -> refresh starts within 2 cycles and shows 00000005.
- Assert rst for 1 cycle during L1CHR:
  - Next cycle lcd_e=0, lcd_dat=0, busy=1.
  - Full 20000-cycle wait and init repeat.
